// File: rtl/demux1_8_deser_if.sv
// Serial-in / byte-out bundle for the 1:8 deserializer.
// master drives bits and consumes bytes; slave is the deserializer itself.
interface demux1_8_deser_if;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       sync;
    logic [2:0] s;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output bit_in, bit_valid, sync, out_ready,
        input  bit_ready, s, out, out_valid
    );

    modport slave (
        input  bit_in, bit_valid, sync, out_ready,
        output bit_ready, s, out, out_valid
    );
endinterface

// File: rtl/demux1_8_deser.sv
// 1:8 deserializer: bit k lands at out[k]; out_valid rises on the edge taking bit 7.
// Backpressure: stalls only the completing bit while an unconsumed byte is held.
module demux1_8_deser (
    input  logic            clk,
    input  logic            rst_n,
    demux1_8_deser_if.slave bus
);

    logic [6:0] asm_q;
    logic [6:0] asm_d;
    logic [2:0] s_q;
    logic [7:0] out_q;
    logic       out_valid_q;

    logic       last_pos;
    logic       pop;
    logic       bit_ready;
    logic       accept;
    logic       complete;

    assign last_pos  = (s_q == 3'd7);
    assign pop       = out_valid_q && bus.out_ready;
    // A pop on the same edge frees the output register for the completing bit.
    assign bit_ready = !(last_pos && out_valid_q && !bus.out_ready);
    assign accept    = bus.bit_valid && bit_ready && !bus.sync;
    assign complete  = accept && last_pos;

    always_comb begin
        asm_d = asm_q;
        if (bus.sync || complete) begin
            asm_d = 7'd0;
        end else if (accept) begin
            for (int i = 0; i < 7; i++) begin
                if (s_q == 3'(i)) begin
                    asm_d[i] = bus.bit_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= 7'd0;
            s_q   <= 3'd0;
        end else begin
            asm_q <= asm_d;
            if (bus.sync) begin
                s_q <= 3'd0;
            end else if (accept) begin
                s_q <= s_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            if (complete) begin
                out_q       <= {bus.bit_in, asm_q};
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.bit_ready = bit_ready;
    assign bus.s         = s_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Scoreboard bench for demux1_8_deser: model keeps accepted bits in a queue and
// queues each completed byte; a negedge monitor checks every presented byte.
module tb_demux1_8_deser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1_8_deser_if bus ();

    demux1_8_deser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    logic bits_m[$];
    logic [7:0] exp_q[$];
    int   ordy_mode = 1;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic pick_ordy();
        if (ordy_mode == 0) return 1'b0;
        if (ordy_mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic beat(input logic v, input logic b, input logic sy, input logic ordy,
                        output logic acc);
        logic rdy_m;
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.sync      = sy;
        bus.out_ready = ordy;
        rdy_m = !(bits_m.size() == 7 && exp_q.size() != 0 && !ordy);
        #1;
        check("bit_ready", {7'd0, bus.bit_ready}, {7'd0, rdy_m});
        check("s", {5'd0, bus.s}, 8'(bits_m.size()));
        @(posedge clk);
        acc = v && rdy_m && !sy;
        if (sy) begin
            bits_m.delete();
        end else if (acc) begin
            bits_m.push_back(b);
            if (bits_m.size() == 8) begin
                logic [7:0] byte_m;
                for (int k = 0; k < 8; k++) byte_m[k] = bits_m[k];
                exp_q.push_back(byte_m);
                bits_m.delete();
            end
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        logic acc;
        for (int n = 0; n < 16; n++) begin
            beat(1'b1, b, 1'b0, pick_ordy(), acc);
            if (acc) return;
        end
        compared++;
        mismatched++;
        $display("FAIL send_bit: bit never accepted within 16 cycles at %0t", $time);
    endtask

    task automatic send_bits(input logic [7:0] d, input int n, input bit gaps);
        logic acc;
        for (int k = 0; k < n; k++) begin
            send_bit(d[k]);
            if (gaps) beat(1'b0, 1'($urandom_range(0, 1)), 1'b0, pick_ordy(), acc);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 1'b0, pick_ordy(), acc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", {7'd0, bus.out_valid}, {7'd0, exp_q.size() != 0});
            if (bus.out_valid && exp_q.size() != 0) begin
                check("out", bus.out, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic hold;
        logic v;
        logic b;
        logic sy;
        logic [7:0] d;

        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("reset s", {5'd0, bus.s}, 8'h00);
        check("reset out", bus.out, 8'h00);
        check("reset out_valid", {7'd0, bus.out_valid}, 8'h00);
        check("reset bit_ready", {7'd0, bus.bit_ready}, 8'h01);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte, consumer always ready
        ordy_mode = 1;
        send_bits(8'h4D, 8, 1'b0);
        idle(3);

        // back-pressure: A5 held, completing bit of 3C stalls, then pop+complete
        ordy_mode = 0;
        send_bits(8'hA5, 8, 1'b0);
        d = 8'h3C;
        send_bits(d, 7, 1'b0);
        beat(1'b1, d[7], 1'b0, 1'b0, acc);
        beat(1'b1, d[7], 1'b0, 1'b0, acc);
        beat(1'b1, d[7], 1'b0, 1'b1, acc);
        ordy_mode = 1;
        idle(2);

        // simultaneous pop and completion: FF held, 7 ones then a zero
        ordy_mode = 0;
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h7F, 7, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b1, acc);
        idle(2);
        ordy_mode = 1;
        idle(2);

        // sync mid-byte with a pending byte held across it
        ordy_mode = 0;
        send_bits(8'h5A, 8, 1'b0);
        send_bits(8'h07, 3, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 1'b0, acc);
        idle(2);
        ordy_mode = 1;
        send_bits(8'h81, 8, 1'b0);
        idle(2);

        // asynchronous reset at s == 5 with a byte pending
        ordy_mode = 0;
        send_bits(8'hC3, 8, 1'b0);
        send_bits(8'h1F, 5, 1'b0);
        bus.bit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        bits_m.delete();
        exp_q.delete();
        #1;
        check("async rst s", {5'd0, bus.s}, 8'h00);
        check("async rst out", bus.out, 8'h00);
        check("async rst out_valid", {7'd0, bus.out_valid}, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ordy_mode = 1;
        send_bits(8'h96, 8, 1'b0);
        idle(2);

        // idle gaps between every bit
        send_bits(8'hB2, 8, 1'b1);
        idle(2);

        // randomized traffic
        ordy_mode = 2;
        hold = 1'b0;
        v = 1'b0;
        b = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom_range(0, 1));
            end
            sy = ($urandom_range(0, 15) == 0);
            beat(v, b, sy, pick_ordy(), acc);
            hold = v && !acc && !sy;
        end

        ordy_mode = 1;
        idle(4);
        check("drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux1_8_deser.md
# demux1_8_deser

Sequential 1-to-8 demultiplexing deserializer. A serial bit stream is steered, one bit per accepted beat, into successive positions of an 8-bit assembly register, using a 3-bit position select. Each completed byte is presented on a registered parallel output with a valid/ready handshake. It is the receive end of the 8:1 selection path: bit index k selected by the mux on select value k lands at out[k] here.

## Interface
- No parameters; widths are fixed (8 data bits, 3-bit select).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  the block can accept a bit this cycle (combinational).
- sync  input  1  synchronous framing restart; discards any partial byte.
- s  output  3  position the next accepted bit is written to (registered counter).
- out  output  8  last completed byte (registered).
- out_valid  output  1  out holds an unconsumed byte.
- out_ready  input  1  consumer takes out this cycle.

## Operation
- State:
  - asm[6:0]: assembly register for positions 0..6.
  - s[2:0]: position counter.
  - out[7:0]: output register.
  - out_valid.
- Accept: a bit is accepted on an edge where bit_valid && bit_ready && !sync.
- Steering:
  - An accepted bit is written to position s: asm[s] when s < 7; then s <= s+1.
  - When s == 7, the completing edge does all of:
    - out <= {bit_in, asm[6:0]}
    - out_valid <= 1
    - s wraps to 0
    - asm cleared to 0
- bit_ready = !(s == 7 && out_valid && !out_ready).
  - Positions 0..6 are always accepted.
  - The completing bit is accepted only if the output register is empty or is being popped that same cycle.
- Pop: out_valid && out_ready at an edge clears out_valid. out keeps its last value, which is don't-care once invalid.
- Pop and completion on the same edge: the new byte loads and out_valid stays 1. No byte is lost or duplicated.
- sync = 1 at an edge:
  - s <= 0 and asm <= 0; any bit_in that cycle is discarded.
  - out and out_valid are unaffected, and a pop in the same cycle still occurs.
- Bits are only ever written at position s. No other asm bit changes except on completion or sync clear.
- Reset (rst_n low, asynchronous): s=0, asm=0, out=8'h00, out_valid=0. bit_ready is 1 from the first cycle after reset is released.
- Reset asserted mid-byte: the partial byte and any pending output byte are discarded immediately.

## Timing
- Latency: out_valid rises on the same edge that accepts the 8th bit, so it is visible the following cycle.
- Throughput: one bit per cycle sustained, as long as each byte is popped within 7 cycles of its completion.
- Back-pressure: stalls occur only at s == 7. bit_ready drops combinationally from out_valid, out_ready and s. There is no combinational path from bit_valid to bit_ready.
- s, out and out_valid are registered outputs. bit_ready is the only combinational output.
- The producer must hold bit_in and bit_valid while bit_ready is 0. Dropping bit_valid while stalled is legal; nothing is recorded.
- Gaps (bit_valid = 0) hold all state; there is no timeout.

## Test plan
- Reset then a single byte: after rst_n release, feed bits 1,0,1,1,0,0,1,0 (positions 0..7) on 8 consecutive cycles with out_ready = 1.
  - s steps 0..7 then 0.
  - out = 8'h4D and out_valid = 1 for exactly one cycle.
- Back-pressure: with out_ready = 0, stream byte 8'hA5 then byte 8'h3C.
  - After the 7th bit of the second byte, bit_ready = 0 while s = 7.
  - out stays 8'hA5.
  - Raise out_ready: on that edge out becomes 8'h3C, out_valid stays 1, and bit_ready returns to 1.
- Simultaneous pop and complete: out_valid = 1 holding 8'hFF, s = 7, and bit_valid = out_ready = 1 on the same cycle with bit_in = 0 and asm = 7'h7F.
  - Next cycle out = 8'h7F and out_valid = 1.
- sync mid-byte: accept 3 bits (s = 3), assert sync with bit_valid = 1, then send 8 bits for 8'h81.
  - s = 0 after the sync cycle; the sync-cycle bit is dropped.
  - The next byte is 8'h81.
  - A pending out_valid survives the sync.
- Async reset mid-stream: assert rst_n low between clock edges at s = 5 with out_valid = 1.
  - s = 0, out = 8'h00 and out_valid = 0 immediately, without waiting for a clock edge.
  - The next 8 bits form a clean byte.
- Idle gaps: a byte is sent with bit_valid toggling 1,0 on alternate cycles.
  - Result equals the same bits sent back-to-back.
  - s holds during the gaps.
